// File: rtl/mmio_controller.sv
// mmio_controller: bridges a single-outstanding CPU valid/ready request channel
// onto a set of MMIO slots. It decodes the slot index from the upper address bits
// and drives that slot's chip select and strobes until the slot reports done.
// It then returns read data and an error code on a valid/ready response channel.
//
// Optional feature: define MMIO_TIMEOUT_EN to bound the ACCESS state with an
// up-counter. When the counter reaches TIMEOUT_CYCLES without a done, the access
// is aborted with error code 11. Without the macro, ACCESS waits indefinitely.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | req_ready high, waiting for a CPU request
// ACCESS | selected slot driven, waiting for its rd/wr done (or timeout)
// RESP   | rsp_valid high, response held until rsp_ready

module mmio_controller #(
    parameter int NUM_SLOTS      = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      arst_i,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [31:0]               req_wdata_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic [1:0]                rsp_err_o,

    output logic [NUM_SLOTS-1:0]      slot_cs_o,
    output logic                      slot_read_o,
    output logic                      slot_write_o,
    output logic [3:0]                slot_addr_o,
    output logic [31:0]               slot_wr_data_o,
    input  logic [32*NUM_SLOTS-1:0]   slot_rd_data_i,
    input  logic [NUM_SLOTS-1:0]      slot_rd_done_i,
    input  logic [NUM_SLOTS-1:0]      slot_wr_done_i,
    input  logic [NUM_SLOTS-1:0]      slot_slave_error_i,
    input  logic [NUM_SLOTS-1:0]      slot_decode_error_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_SLAVE   = 2'b01;
    localparam logic [1:0] ERR_DECODE  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    state_t state_q, state_d;

    // The slot-facing registers double as the request latches: while in ACCESS
    // they hold the accepted direction, register address and write data.
    logic [NUM_SLOTS-1:0] slot_cs_q, slot_cs_d;
    logic                 slot_read_q, slot_read_d;
    logic                 slot_write_q, slot_write_d;
    logic [3:0]           slot_addr_q, slot_addr_d;
    logic [31:0]          slot_wr_data_q, slot_wr_data_d;
    logic [31:0]          rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_err_q, rsp_err_d;

    logic [31:0]          req_slot;
    logic                 req_in_range;
    logic [NUM_SLOTS-1:0] req_onehot;
    logic                 done_hit;
    logic                 dec_hit;
    logic                 slv_hit;
    logic [31:0]          sel_rdata;
    logic                 timeout_hit;

    // Slot index compare is done in 32 bits so any ADDR_W / NUM_SLOTS mix works.
    assign req_slot     = 32'(req_addr_i[ADDR_W-1:4]);
    assign req_in_range = (req_slot < 32'(NUM_SLOTS));

    // One-hot select for the requested slot (all zero when out of range).
    always_comb begin
        req_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            req_onehot[i] = (req_slot == 32'(i));
        end
    end

    // Status and read data are qualified by the registered chip select. Any
    // non-selected slot is masked off, and nothing is selected outside ACCESS,
    // so trailing done pulses cannot leak into a later transaction.
    assign done_hit = slot_write_q ? |(slot_wr_done_i & slot_cs_q)
                                   : |(slot_rd_done_i & slot_cs_q);
    assign dec_hit  = |(slot_decode_error_i & slot_cs_q);
    assign slv_hit  = |(slot_slave_error_i & slot_cs_q);

    // Read-data mux: OR of the selected slot's word.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_cs_q[i]) begin
                sel_rdata = sel_rdata | slot_rd_data_i[32*i +: 32];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The counter holds the number of ACCESS cycles already spent, so the
    // limit is reached during the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timeout_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Access-cycle counter: cleared while idle (i.e. on entry to ACCESS), counts each ACCESS cycle without done.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_IDLE) begin
            tmo_d = '0;
        end else if ((state_q == ST_ACCESS) && !done_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Access-cycle counter register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a done seen together with the timeout limit wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = req_in_range ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                if (done_hit || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: next values for the registered slot and response outputs.
    always_comb begin
        slot_cs_d      = slot_cs_q;
        slot_read_d    = slot_read_q;
        slot_write_d   = slot_write_q;
        slot_addr_d    = slot_addr_q;
        slot_wr_data_d = slot_wr_data_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_err_d      = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (req_in_range) begin
                        slot_cs_d      = req_onehot;
                        slot_read_d    = ~req_write_i;
                        slot_write_d   = req_write_i;
                        slot_addr_d    = req_addr_i[3:0];
                        slot_wr_data_d = req_wdata_i;
                    end else begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = ERR_DECODE;
                    end
                end
            end
            ST_ACCESS: begin
                if (done_hit || timeout_hit) begin
                    slot_cs_d      = '0;
                    slot_read_d    = 1'b0;
                    slot_write_d   = 1'b0;
                    slot_addr_d    = '0;
                    slot_wr_data_d = '0;
                end
                if (done_hit) begin
                    if (dec_hit) begin
                        rsp_err_d   = ERR_DECODE;
                        rsp_rdata_d = '0;
                    end else if (slv_hit) begin
                        rsp_err_d   = ERR_SLAVE;
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = slot_read_q ? sel_rdata : 32'h0;
                    end
                end else if (timeout_hit) begin
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = ERR_OK;
                end
            end
            default: begin
                slot_cs_d    = '0;
                slot_read_d  = 1'b0;
                slot_write_d = 1'b0;
            end
        endcase
    end

    // Registered slot-side and response-side outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            slot_cs_q      <= '0;
            slot_read_q    <= 1'b0;
            slot_write_q   <= 1'b0;
            slot_addr_q    <= '0;
            slot_wr_data_q <= '0;
            rsp_rdata_q    <= '0;
            rsp_err_q      <= ERR_OK;
        end else begin
            slot_cs_q      <= slot_cs_d;
            slot_read_q    <= slot_read_d;
            slot_write_q   <= slot_write_d;
            slot_addr_q    <= slot_addr_d;
            slot_wr_data_q <= slot_wr_data_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_err_q      <= rsp_err_d;
        end
    end

    // req_ready is forced low for as long as reset is held.
    assign req_ready_o    = (state_q == ST_IDLE) && !arst_i;
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_rdata_o    = rsp_rdata_q;
    assign rsp_err_o      = rsp_err_q;
    assign slot_cs_o      = slot_cs_q;
    assign slot_read_o    = slot_read_q;
    assign slot_write_o   = slot_write_q;
    assign slot_addr_o    = slot_addr_q;
    assign slot_wr_data_o = slot_wr_data_q;

endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed bench for mmio_controller with 8 slots.
// Slot 0 models a timer-like peripheral: combinational read done, registered
// write done with a trailing pulse, slave/decode errors. Slot 3 never responds.
// Slot 6 holds all its status lines high and must never be observed.
// Every other slot completes combinationally.
// The remaining slots return {slot, 20'h0, reg} as read data.

module tb_mmio_controller;

    localparam int NS = 8;

    logic          clk;
    logic          arst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [7:0]    req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_err;
    logic [NS-1:0] slot_cs;
    logic          slot_read;
    logic          slot_write;
    logic [3:0]    slot_addr;
    logic [31:0]   slot_wr_data;
    logic [32*NS-1:0] slot_rd_data;
    logic [NS-1:0] slot_rd_done;
    logic [NS-1:0] slot_wr_done;
    logic [NS-1:0] slot_se;
    logic [NS-1:0] slot_de;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_controller #(
        .NUM_SLOTS      (NS),
        .ADDR_W         (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_write_i         (req_write),
        .req_addr_i          (req_addr),
        .req_wdata_i         (req_wdata),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_rdata_o         (rsp_rdata),
        .rsp_err_o           (rsp_err),
        .slot_cs_o           (slot_cs),
        .slot_read_o         (slot_read),
        .slot_write_o        (slot_write),
        .slot_addr_o         (slot_addr),
        .slot_wr_data_o      (slot_wr_data),
        .slot_rd_data_i      (slot_rd_data),
        .slot_rd_done_i      (slot_rd_done),
        .slot_wr_done_i      (slot_wr_done),
        .slot_slave_error_i  (slot_se),
        .slot_decode_error_i (slot_de)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot 0 registered write side: done one cycle late, trailing pulse, errors aligned with done.
    logic        wd1, wd2, se1, dew1;
    logic [31:0] reg2;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            wd1 <= 1'b0; wd2 <= 1'b0; se1 <= 1'b0; dew1 <= 1'b0; reg2 <= 32'h0;
        end else begin
            wd1  <= slot_cs[0] & slot_write;
            wd2  <= wd1;
            se1  <= slot_cs[0] & slot_write & ((slot_addr == 4'h0) || (slot_addr == 4'h9));
            dew1 <= slot_cs[0] & slot_write & (slot_addr == 4'h9);
            if (slot_cs[0] && slot_write && slot_addr == 4'h2) reg2 <= slot_wr_data;
        end
    end

    // Slot status/data models.
    always_comb begin
        slot_rd_done = '0;
        slot_wr_done = '0;
        slot_se      = '0;
        slot_de      = '0;
        slot_rd_data = '0;
        for (int i = 0; i < NS; i++) begin
            slot_rd_data[32*i +: 32] = {8'(i), 20'h0, slot_addr};
            if (i != 0 && i != 3 && i != 6) begin
                slot_rd_done[i] = slot_cs[i] & slot_read;
                slot_wr_done[i] = slot_cs[i] & slot_write;
            end
        end
        slot_rd_data[31:0] = (slot_addr == 4'h1) ? 32'h0000_0064 :
                             (slot_addr == 4'h2) ? reg2 : {16'hDEAD, 12'h0, slot_addr};
        slot_rd_done[0] = slot_cs[0] & slot_read;
        slot_wr_done[0] = wd1 | wd2;
        slot_se[0]      = se1;
        slot_de[0]      = (slot_cs[0] & slot_read & (slot_addr == 4'h9)) | dew1;
        slot_rd_done[6] = 1'b1;
        slot_wr_done[6] = 1'b1;
        slot_se[6]      = 1'b1;
        slot_de[6]      = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Present one request at a negedge; it is accepted at the following posedge.
    task automatic accept(input logic wr, input logic [7:0] addr, input logic [31:0] wd);
        @(negedge clk);
        check("req_ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Full transaction: latency is counted in cycles after the accept edge.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic [1:0] exp_err,
                           input int exp_lat, input int hold, input logic early);
        logic [7:0] exp_cs;
        int         lat;
        int         cs_cycles;
        logic       cs_bad;
        exp_cs    = (addr[7:4] < 4'd8) ? (8'h01 << addr[7:4]) : 8'h00;
        lat       = 0;
        cs_cycles = 0;
        cs_bad    = 1'b0;
        rsp_ready = early;
        accept(wr, addr, wd);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (slot_cs != 8'h00) begin
                cs_cycles++;
                if (slot_cs != exp_cs || slot_write != wr || slot_read != !wr ||
                    slot_addr != addr[3:0] || (wr && slot_wr_data != wd)) cs_bad = 1'b1;
            end
            if (rsp_valid) lat = k;
        end
        check("rsp_latency", lat, exp_lat);
        if (lat != 0) begin
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", {30'h0, rsp_err}, {30'h0, exp_err});
            check("cs_low_in_resp", {24'h0, slot_cs}, 0);
        end
        check("cs_cycles", cs_cycles, (exp_cs != 8'h00) ? exp_lat - 1 : 0);
        check("slot_drive_stable", {31'h0, cs_bad}, 0);
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("resp_hold", {rsp_valid, rsp_err, rsp_rdata[28:0]},
                      {1'b1, exp_err, exp_rd[28:0]});
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("back_to_idle", {30'h0, rsp_valid, req_ready}, 32'h1);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
        int          exp_lat;
        int          hold;
        logic        early;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        vecs[0]  = '{1'b0, 8'h01, 32'h0,        32'h0000_0064, 2'b00, 2, 0, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 32'h3,        32'h0,         2'b00, 3, 0, 1'b0};
        vecs[2]  = '{1'b0, 8'h02, 32'h0,        32'h0000_0003, 2'b00, 2, 0, 1'b0};
        vecs[3]  = '{1'b1, 8'h00, 32'h55,       32'h0,         2'b01, 3, 0, 1'b0};
        vecs[4]  = '{1'b0, 8'h09, 32'h0,        32'h0,         2'b10, 2, 0, 1'b0};
        vecs[5]  = '{1'b1, 8'h09, 32'h1,        32'h0,         2'b10, 3, 0, 1'b0};
        vecs[6]  = '{1'b0, 8'h90, 32'h0,        32'h0,         2'b10, 1, 0, 1'b0};
        vecs[7]  = '{1'b0, 8'h15, 32'h0,        32'h0100_0005, 2'b00, 2, 0, 1'b1};
        vecs[8]  = '{1'b0, 8'h7F, 32'h0,        32'h0700_000F, 2'b00, 2, 0, 1'b0};
        vecs[9]  = '{1'b1, 8'h7A, 32'hCAFE_0001, 32'h0,        2'b00, 2, 0, 1'b0};
        vecs[10] = '{1'b0, 8'h80, 32'h0,        32'h0,         2'b10, 1, 0, 1'b1};
        vecs[11] = '{1'b0, 8'hF0, 32'h0,        32'h0,         2'b10, 1, 2, 1'b0};
        vecs[12] = '{1'b0, 8'h23, 32'h0,        32'h0200_0003, 2'b00, 2, 3, 1'b0};

        arst      = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 8'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", {30'h0, rsp_err}, 0);
        check("rst_slot_cs", {24'h0, slot_cs}, 0);
        check("rst_slot_strobes", {30'h0, slot_read, slot_write}, 0);
        check("rst_slot_addr_data", slot_wr_data | {28'h0, slot_addr}, 0);
        arst = 1'b0;
        #1;
        check("req_ready_after_release", req_ready, 1);

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err,
                    vecs[i].exp_lat, vecs[i].hold, vecs[i].early);
        end

`ifdef MMIO_TIMEOUT_EN
        run_txn(1'b0, 8'h30, 32'h0, 32'h0, 2'b11, 5, 0, 1'b0);
        accept(1'b0, 8'h30, 32'h0);
        repeat (2) @(negedge clk);
        check("access_before_reset", {24'h0, slot_cs}, 32'h08);
`else
        accept(1'b0, 8'h30, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("hang_no_rsp", {31'h0, seen}, 0);
        check("hang_cs", {24'h0, slot_cs}, 32'h08);
        check("hang_read", {31'h0, slot_read}, 1);
`endif

        #2;
        arst = 1'b1;
        #1;
        check("arst_cs_drop", {24'h0, slot_cs}, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_req_ready", req_ready, 0);
        check("arst_strobes", {30'h0, slot_read, slot_write}, 0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("req_ready_after_arst", req_ready, 1);
        run_txn(1'b0, 8'h01, 32'h0, 32'h0000_0064, 2'b00, 2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
